// File: rtl/dcache_stall_ctrl_if.sv
// dcache_stall_ctrl_if: MEM-stage access/tag inputs and backing-memory bus of the miss sequencer (stallCount only with DCACHE_STALL_CNT_EN)
interface dcache_stall_ctrl_if #(parameter int ADDR_W = 64);
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] addr;
  logic              tagHit;
  logic              dirty;
  logic [ADDR_W-1:0] victimAddr;
  logic              memAck;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic              fillEn;
  logic              hit;
  logic              busErr;
`ifdef DCACHE_STALL_CNT_EN
  logic [31:0]       stallCount;
  modport master(output memRead, memWrite, addr, tagHit, dirty, victimAddr, memAck,
                 input memReq, memWe, memAddr, fillEn, hit, busErr, stallCount);
  modport slave(input memRead, memWrite, addr, tagHit, dirty, victimAddr, memAck,
                output memReq, memWe, memAddr, fillEn, hit, busErr, stallCount);
`else
  modport master(output memRead, memWrite, addr, tagHit, dirty, victimAddr, memAck,
                 input memReq, memWe, memAddr, fillEn, hit, busErr);
  modport slave(input memRead, memWrite, addr, tagHit, dirty, victimAddr, memAck,
                output memReq, memWe, memAddr, fillEn, hit, busErr);
`endif
endinterface

// File: rtl/dcache_stall_ctrl.sv
// dcache_stall_ctrl: D-cache miss sequencer and pipeline stall control; DCACHE_STALL_CNT_EN adds the stallCount counter
module dcache_stall_ctrl #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             reset,
  dcache_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WBACK, REFILL, FILL, ERR} state_t;
  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_fill_en;
  logic              r_bus_err;
  logic [ADDR_W-1:0] r_miss_addr;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [CW-1:0]     r_to_cnt;
  logic              w_access;
  logic              w_miss;
  logic              w_hit;
  assign w_access = bus.memRead | bus.memWrite;
  assign w_miss   = (r_state == IDLE) && w_access && !bus.tagHit;
  // Combinational: pipeline registers sample hit on the negedge of this same cycle.
  assign w_hit    = (r_state == IDLE) && !(w_access && !bus.tagHit);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_fill_en   <= 1'b0;
      r_bus_err   <= 1'b0;
      r_miss_addr <= '0;
      r_wb_addr   <= '0;
      r_to_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_miss) begin
          r_miss_addr <= bus.addr;
          r_wb_addr   <= bus.victimAddr;
          r_to_cnt    <= '0;
          r_mem_req   <= 1'b1;
          r_mem_we    <= bus.dirty;
          r_state     <= bus.dirty ? WBACK : REFILL;
        end
        WBACK, REFILL: if (bus.memAck) begin
          r_to_cnt  <= '0;
          r_mem_we  <= 1'b0;
          r_mem_req <= (r_state == WBACK);
          r_fill_en <= (r_state == REFILL);
          r_state   <= (r_state == WBACK) ? REFILL : FILL;
        end else if (r_to_cnt == TO_LIM) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_bus_err <= 1'b1;
          r_state   <= ERR;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
        FILL: begin
          r_fill_en <= 1'b0;
          r_state   <= IDLE;
        end
        ERR: r_state <= ERR;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.memReq  = r_mem_req;
  assign bus.memWe   = r_mem_we;
  assign bus.memAddr = r_mem_req ? (r_mem_we ? r_wb_addr : r_miss_addr) : '0;
  assign bus.fillEn  = r_fill_en;
  assign bus.hit     = w_hit;
  assign bus.busErr  = r_bus_err;
`ifdef DCACHE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_stall_cnt <= '0;
    else if (!w_hit && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
  assign bus.stallCount = r_stall_cnt;
`endif
endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// tb_dcache_stall_ctrl: transaction-queue reference model with per-cycle compare plus directed literal checks
module tb_dcache_stall_ctrl;
  localparam int AW = 64;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dcache_stall_ctrl_if #(.ADDR_W(AW)) bus();
  dcache_stall_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut(.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct {logic we; logic [AW-1:0] a;} txn_t;
  txn_t q[$];
  bit m_fill = 0;
  bit m_err = 0;
  int m_wait = 0;
  longint unsigned m_stall = 0;
  int n_hit_low, n_req, n_fill, n_wb, n_rf;
  logic [AW-1:0] tgt_wb, tgt_rf;
  bit rnd = 0, auto_fill = 0, stray = 0;
  int ack_delay = 99, cur_delay = 0, age = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_hit();
    return !m_err && !m_fill && q.size() == 0 && !((bus.memRead | bus.memWrite) && !bus.tagHit);
  endfunction

  // Model: a miss queues its bus transactions; each needs an ack within TO cycles.
  always @(posedge clk) begin
    if (reset) begin
      q.delete(); m_fill = 0; m_err = 0; m_wait = 0; m_stall = 0;
    end else begin
      if (!exp_hit() && m_stall != 64'hFFFF_FFFF) m_stall++;
      if (m_err) begin
      end else if (m_fill) m_fill = 0;
      else if (q.size() != 0) begin
        if (bus.memAck) begin
          void'(q.pop_front());
          m_wait = 0;
          if (q.size() == 0) m_fill = 1;
        end else if (m_wait == TO - 1) begin
          m_err = 1;
          q.delete();
        end else m_wait++;
      end else if ((bus.memRead | bus.memWrite) && !bus.tagHit) begin
        if (bus.dirty) q.push_back('{1'b1, bus.victimAddr});
        q.push_back('{1'b0, bus.addr});
        m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic e_req, e_we;
    logic [AW-1:0] e_addr;
    e_req = !m_err && !m_fill && q.size() != 0;
    e_we = 0;
    e_addr = '0;
    if (e_req) begin
      e_we = q[0].we;
      e_addr = q[0].a;
    end
    chk("hit", bus.hit, exp_hit());
    chk("memReq", bus.memReq, e_req);
    chk("memWe", bus.memWe, e_we);
    chk("memAddr", bus.memAddr, e_addr);
    chk("fillEn", bus.fillEn, m_fill);
    chk("busErr", bus.busErr, m_err);
`ifdef DCACHE_STALL_CNT_EN
    chk("stallCount", bus.stallCount, m_stall);
`endif
    if (!bus.hit) n_hit_low++;
    if (bus.memReq) n_req++;
    if (bus.fillEn) n_fill++;
    if (bus.memReq && bus.memWe && bus.memAddr == tgt_wb) n_wb++;
    if (bus.memReq && !bus.memWe && bus.memAddr == tgt_rf) n_rf++;
  end

  task automatic respond();
    if (bus.memReq) begin
      if (age == 0) cur_delay = rnd ? int'($urandom_range(0, 4)) : ack_delay;
      bus.memAck = (age == cur_delay);
      age = bus.memAck ? 0 : age + 1;
    end else begin
      age = 0;
      bus.memAck = rnd ? ($urandom_range(0, 9) == 0) : stray;
    end
    if (auto_fill && bus.fillEn) bus.tagHit = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic clr();
    n_hit_low = 0; n_req = 0; n_fill = 0; n_wb = 0; n_rf = 0;
  endtask

  task automatic miss(input bit wr, input logic [AW-1:0] a, input bit d, input logic [AW-1:0] v, input int dl, input bit af);
    bus.memRead = !wr; bus.memWrite = wr; bus.addr = a; bus.dirty = d; bus.victimAddr = v;
    bus.tagHit = 0; ack_delay = dl; auto_fill = af; tgt_rf = a; tgt_wb = v;
    clr();
  endtask

  initial begin
    bus.memRead = 0; bus.memWrite = 0; bus.addr = '0; bus.tagHit = 0; bus.dirty = 0;
    bus.victimAddr = '0; bus.memAck = 0;
    tgt_wb = '1; tgt_rf = '1;
    clr();
    repeat (3) cyc();
    reset = 0;
    chk("rst_hit", bus.hit, 1);
    chk("rst_memReq", bus.memReq, 0);
    chk("rst_busErr", bus.busErr, 0);
    bus.memRead = 1; bus.tagHit = 1; bus.addr = 64'h0000_0000_0000_0ff0;
    clr();
    repeat (10) cyc();
    chk("hits_req_cycles", n_req, 0);
    chk("hits_stall_cycles", n_hit_low, 0);
`ifdef DCACHE_STALL_CNT_EN
    chk("hits_stallCount", bus.stallCount, 0);
`endif
    miss(0, 64'h1000, 0, 64'h9000, 2, 1);
    repeat (8) cyc();
    bus.memRead = 0; auto_fill = 0;
    chk("clean_stall_cycles", n_hit_low, 5);
    chk("clean_refill_cycles", n_rf, 3);
    chk("clean_req_cycles", n_req, 3);
    chk("clean_fill_pulses", n_fill, 1);
`ifdef DCACHE_STALL_CNT_EN
    chk("clean_stallCount", bus.stallCount, 5);
`endif
    miss(1, 64'h2040, 1, 64'h8040, 0, 1);
    repeat (8) cyc();
    bus.memWrite = 0; auto_fill = 0;
    chk("dirty_stall_cycles", n_hit_low, 4);
    chk("dirty_wb_cycles", n_wb, 1);
    chk("dirty_refill_cycles", n_rf, 1);
    chk("dirty_fill_pulses", n_fill, 1);
    miss(0, 64'h3000, 0, 64'h0, 99, 0);
    repeat (8) cyc();
    chk("to_req_cycles", n_req, 4);
    chk("to_busErr", bus.busErr, 1);
    chk("to_hit", bus.hit, 0);
    chk("to_fill_pulses", n_fill, 0);
    reset = 1; bus.memRead = 0;
    cyc();
    reset = 0;
    chk("to_rst_busErr", bus.busErr, 0);
    chk("to_rst_hit", bus.hit, 1);
    miss(0, 64'h4000, 0, 64'h0, TO - 1, 1);
    repeat (10) cyc();
    bus.memRead = 0; auto_fill = 0;
    chk("lim_fill_pulses", n_fill, 1);
    chk("lim_req_cycles", n_req, 4);
    chk("lim_busErr", bus.busErr, 0);
    miss(0, 64'h5000, 0, 64'h0, 99, 0);
    cyc();
    cyc();
    reset = 1; bus.memRead = 0;
    cyc();
    reset = 0;
    chk("mid_rst_memReq", bus.memReq, 0);
    stray = 1;
    cyc();
    stray = 0;
    repeat (3) cyc();
    chk("mid_rst_fill_pulses", n_fill, 0);
    chk("mid_rst_req_after", bus.memReq, 0);
    chk("mid_rst_hit", bus.hit, 1);
    rnd = 1;
    for (int i = 0; i < 600; i++) begin
      cyc();
      reset = (bus.busErr && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0;
      bus.memRead = $urandom_range(0, 2) == 0;
      bus.memWrite = $urandom_range(0, 3) == 0;
      bus.tagHit = $urandom_range(0, 3) != 0;
      bus.dirty = $urandom_range(0, 1) == 1;
      bus.addr = {$urandom, $urandom};
      bus.victimAddr = {$urandom, $urandom};
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
